// File: rtl/rr_mux4way_pkg.sv
// Shared constants for the 4-way round-robin mux: source count, select width,
// pointer reset value and the output-register control state encoding.
package rr_mux4way_pkg;
    localparam int          N_SRC     = 4;
    localparam int          SEL_W     = 2;
    localparam logic [1:0]  PTR_RESET = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
endpackage

// File: rtl/rr_mux4way_arbiter.sv
// Purpose: 4-input round-robin arbiter, search starts one past the last grant.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load condition.
module rr_arbiter4
    import rr_mux4way_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_SRC-1:0] gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);
    logic [SEL_W-1:0] idx;

    // Offset 4 wraps to ptr itself, so the last grantee has lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = ptr + SEL_W'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/rr_mux4way.sv
// Purpose: merges four valid/ready sources onto one registered output, round-robin; out_sel under RR_MUX4WAY_TAG_EN.
// Latency: one cycle from input handshake to out_valid; one beat per cycle sustained.
// Backpressure: register loads when empty or draining; otherwise all in_ready are held low.
module rr_mux4way
    import rr_mux4way_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       in_valid,
    input  logic [N_SRC*WIDTH-1:0] in_data,
    output logic [N_SRC-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready
`ifdef RR_MUX4WAY_TAG_EN
    ,
    output logic [SEL_W-1:0]       out_sel
`endif
);
    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [N_SRC-1:0] gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             any;
    logic             load;
    logic             xfer;

    rr_arbiter4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign load     = ~out_valid | out_ready;
    // Reset gates ready so no producer believes a beat was taken while the register is cleared.
    assign in_ready = (load && !reset) ? gnt : '0;
    assign xfer     = load & any;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (xfer) state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !xfer) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= PTR_RESET;
            out_data <= '0;
        end else if (xfer) begin
            ptr      <= gnt_idx;
            out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
        end
    end

`ifdef RR_MUX4WAY_TAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     out_sel <= '0;
        else if (xfer) out_sel <= gnt_idx;
    end
`endif
endmodule

// File: tb/tb_rr_mux4way.sv
// Directed bench for rr_mux4way: reset, single source, round-robin order,
// back-pressure, pointer wrap, idle drain and reset mid-transfer.
module tb_rr_mux4way;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef RR_MUX4WAY_TAG_EN
    logic [1:0]       out_sel;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] dv [4];

    rr_mux4way #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef RR_MUX4WAY_TAG_EN
        ,
        .out_sel   (out_sel)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'hA5; dv[3] = 8'h44;
        reset     = 1'b1;
        in_valid  = 4'b0000;
        in_data   = {dv[3], dv[2], dv[1], dv[0]};
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // single source 2
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(in_ready), 32'b0100);
        tick;
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'hA5);
`ifdef RR_MUX4WAY_TAG_EN
        chk("single_out_sel", 32'(out_sel), 32'd2);
`endif

        // idle drain: ptr stays 2
        in_valid = 4'b0000;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        tick;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_data_hold", 32'(out_data), 32'hA5);

        // all valid after idle: ptr=2 so source 3 wins
        in_valid = 4'b1111;
        #1;
        chk("idle_ptr_grant", 32'(in_ready), 32'b1000);
        tick;
        chk("idle_ptr_data", 32'(out_data), 32'h44);

        // round-robin 0,1,2,3,0 back-to-back
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (s % 4)));
            tick;
            chk("rr_out_valid", 32'(out_valid), 32'd1);
            chk("rr_out_data", 32'(out_data), 32'(dv[s % 4]));
`ifdef RR_MUX4WAY_TAG_EN
            chk("rr_out_sel", 32'(out_sel), 32'(s % 4));
`endif
        end

        // back-pressure for 5 cycles, holding source 0 beat
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            tick;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h11);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'b0010);
        tick;
        chk("bp_release_data", 32'(out_data), 32'h22);

        // sparse: ptr=1, only source 0 -> wrap grant
        in_valid = 4'b0001;
        #1;
        chk("sparse_wrap_in_ready", 32'(in_ready), 32'b0001);
        tick;
        chk("sparse_wrap_data", 32'(out_data), 32'h11);
        in_valid = 4'b1001;
        #1;
        chk("sparse_next_in_ready", 32'(in_ready), 32'b1000);
        tick;
        chk("sparse_next_data", 32'(out_data), 32'h44);

        // move ptr to 1, then reset while a beat is held
        in_valid = 4'b0010;
        tick;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h00);
        tick;
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("after_rst_grant", 32'(in_ready), 32'b0001);
        tick;
        chk("after_rst_data", 32'(out_data), 32'h11);
`ifdef RR_MUX4WAY_TAG_EN
        chk("after_rst_sel", 32'(out_sel), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
